// File: rtl/opc_mem_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared single-port system memory.
// One access at a time; strobes are held for WAIT_STATES extra cycles and read data is registered.
module opc_mem_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 0,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          m0_req,
  input  logic          m0_rnw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rnw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rnw,
  output logic          mem_ceb,
  output logic          mem_oeb,
  output logic          owner,
  output logic          busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_d, busy_d;
  logic          m0_ack_d, m1_ack_d;
  logic [DW-1:0] m0_rdata_d, m1_rdata_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          mem_rnw_d, mem_ceb_d, mem_oeb_d;
  logic          gnt;

  // On a tie the master that did not own the last access wins.
  assign gnt = (m0_req && m1_req) ? ~owner : m1_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner;
    busy_d      = busy;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_rnw_d   = mem_rnw;
    mem_ceb_d   = mem_ceb;
    mem_oeb_d   = mem_oeb;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d     = gnt;
          mem_addr_d  = gnt ? m1_addr  : m0_addr;
          mem_wdata_d = gnt ? m1_wdata : m0_wdata;
          mem_rnw_d   = gnt ? m1_rnw   : m0_rnw;
          mem_oeb_d   = ~(gnt ? m1_rnw : m0_rnw);
          mem_ceb_d   = 1'b0;
          cnt_d       = CW'(WAIT_STATES);
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Completion: ack the owner and capture read data in the same edge.
          if (owner) begin
            m1_ack_d = 1'b1;
            if (mem_rnw) m1_rdata_d = mem_rdata;
          end else begin
            m0_ack_d = 1'b1;
            if (mem_rnw) m0_rdata_d = mem_rdata;
          end
          mem_ceb_d = 1'b1;
          mem_oeb_d = 1'b1;
          mem_rnw_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner     <= 1'b1;
      busy      <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rnw   <= 1'b1;
      mem_ceb   <= 1'b1;
      mem_oeb   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner     <= owner_d;
      busy      <= busy_d;
      m0_ack    <= m0_ack_d;
      m1_ack    <= m1_ack_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_rnw   <= mem_rnw_d;
      mem_ceb   <= mem_ceb_d;
      mem_oeb   <= mem_oeb_d;
    end
  end

endmodule
